// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared types and constants for the data-memory load/store unit:
//             RISC-V funct3 size/sign encodings, mcause exception codes and
//             the LSU state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

  // RISC-V load/store size and sign encodings.
  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_funct3_e;

  // mcause exception codes.
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  // LSU controller states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } lsu_state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane logic for the LSU.
//             - Load path: picks the byte/half lane of i_rword selected by
//               i_off and sign- or zero-extends it; words pass unchanged.
//             - Store path: merges the low byte/half of i_wdata into the
//               selected lane of i_old_word; a word store replaces it all.
//  Ports    : i_rword      word read from memory (load path)
//             i_old_word   previously read word (store merge path)
//             i_wdata      store data, low bits used for B/H
//             i_funct3     RISC-V size/sign code
//             i_off        byte offset within the word (addr[1:0])
//             o_load_data  extended load result
//             o_merged     word to write back
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rword,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte      = i_rword[{i_off, 3'b000} +: 8];
    w_half      = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    o_load_data = i_rword;
    case (i_funct3)
      LS_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      LS_BU:   o_load_data = {24'd0, w_byte};
      LS_H:    o_load_data = {{16{w_half[15]}}, w_half};
      LS_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_rword;
    endcase
  end

  always_comb begin
    o_merged = i_old_word;
    case (i_funct3)
      LS_B:    o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      LS_H:    o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lsu
//  Purpose  : Load/store initiator for the word-organised data memory.
//             Accepts one request per handshake, checks it for illegal size,
//             misalignment and range, then performs a word read, a word
//             write, or a read-modify-write for sub-word stores. Every
//             request ends in a single-cycle response pulse.
//  Ports    : clk, rst                   clock, synchronous active-high reset
//             req_*                      request from execute stage
//             resp_*                     completion / exception report
//             mem_*                      data memory interface (cs active low)
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [3:0]  resp_cause_o,
  output logic [31:0] resp_badaddr_o,
  output logic        mem_cs_o,
  output logic        mem_rd_wr_o,
  output logic [2:0]  mem_mask_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [29:0] c_MEM_WORDS = 30'(MEM_WORDS);

  lsu_state_e  r_state, w_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_old;
  logic [31:0] r_rdata, r_badaddr;
  logic        r_err;
  logic [3:0]  r_cause;

  logic        w_bad_f3, w_misalign, w_oor, w_err;
  logic [3:0]  w_cause;
  logic [31:0] w_load_data, w_merged;

  // Request checks, evaluated on the live request while in IDLE.
  always_comb begin
    if (req_we_i)
      w_bad_f3 = !(req_funct3_i == LS_B || req_funct3_i == LS_H || req_funct3_i == LS_W);
    else
      w_bad_f3 = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    w_misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    w_oor      = req_addr_i[31:2] >= c_MEM_WORDS;
    w_err      = w_bad_f3 || w_misalign || w_oor;
    // Illegal size outranks misalignment, which outranks range.
    if (!w_bad_f3 && w_misalign)
      w_cause = req_we_i ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    else
      w_cause = req_we_i ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
  end

  lsu_align u_align (
    .i_rword     (mem_data_i),
    .i_old_word  (r_old),
    .i_wdata     (r_wdata),
    .i_funct3    (r_funct3),
    .i_off       (r_addr[1:0]),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    mem_cs_o    = 1'b1;
    mem_rd_wr_o = 1'b1;
    mem_addr_o  = 32'd0;
    mem_data_o  = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (w_err)                          w_next = S_RESP;
          else if (!req_we_i)                 w_next = S_LOAD;
          else if (req_funct3_i[1:0] == 2'b10) w_next = S_STORE;
          else                                w_next = S_RMW_RD;
        end
      end
      S_LOAD, S_RMW_RD: begin
        mem_cs_o   = 1'b0;
        mem_addr_o = {2'b00, r_addr[31:2]};
        w_next     = (r_state == S_LOAD) ? S_RESP : S_RMW_WR;
      end
      S_STORE: begin
        mem_cs_o    = 1'b0;
        mem_rd_wr_o = 1'b0;
        mem_addr_o  = {2'b00, r_addr[31:2]};
        mem_data_o  = r_wdata;
        w_next      = S_RESP;
      end
      S_RMW_WR: begin
        mem_cs_o    = 1'b0;
        mem_rd_wr_o = 1'b0;
        mem_addr_o  = {2'b00, r_addr[31:2]};
        mem_data_o  = w_merged;
        w_next      = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and response registers. Response fields are written on
  // the edge that enters RESP and hold until the next such edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_old     <= 32'd0;
      r_rdata   <= 32'd0;
      r_err     <= 1'b0;
      r_cause   <= 4'd0;
      r_badaddr <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_funct3 <= req_funct3_i;
            r_addr   <= req_addr_i;
            r_wdata  <= req_wdata_i;
            if (w_err) begin
              r_rdata   <= 32'd0;
              r_err     <= 1'b1;
              r_cause   <= w_cause;
              r_badaddr <= req_addr_i;
            end
          end
        end
        S_LOAD: begin
          r_rdata   <= w_load_data;
          r_err     <= 1'b0;
          r_cause   <= 4'd0;
          r_badaddr <= 32'd0;
        end
        S_RMW_RD: r_old <= mem_data_i;
        S_STORE, S_RMW_WR: begin
          r_rdata   <= 32'd0;
          r_err     <= 1'b0;
          r_cause   <= 4'd0;
          r_badaddr <= 32'd0;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid_o   = (r_state == S_RESP);
  assign resp_rdata_o   = r_rdata;
  assign resp_err_o     = r_err;
  assign resp_cause_o   = r_cause;
  assign resp_badaddr_o = r_badaddr;
  assign mem_mask_o     = 3'b000;

endmodule : data_mem_lsu
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_lsu
//  Purpose  : Self-checking bench for data_mem_lsu with a behavioural memory,
//             a reference model of the load/store rules and a response
//             scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_lsu;
  localparam int MEM_WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [31:0] req_addr_i = 32'd0, req_wdata_i = 32'd0;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o, resp_badaddr_o;
  logic [3:0]  resp_cause_o;
  logic        mem_cs_o, mem_rd_wr_o;
  logic [2:0]  mem_mask_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  data_mem_lsu #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .resp_cause_o(resp_cause_o), .resp_badaddr_o(resp_badaddr_o),
    .mem_cs_o(mem_cs_o), .mem_rd_wr_o(mem_rd_wr_o), .mem_mask_o(mem_mask_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // Behavioural data memory driven by the DUT, and the reference image.
  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        preload = 1'b1;

  assign mem_data_i = dmem[mem_addr_o[3:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_WORDS; i++) dmem[i] <= ref_mem[i];
    end else if (!mem_cs_o && !mem_rd_wr_o) begin
      dmem[mem_addr_o[3:0]] <= mem_data_o;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  cause;
    logic [31:0] badaddr;
    int          lat;
    int          cs;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   cs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the architectural load/store rules to ref_mem.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output exp_t e);
    int unsigned size, off, idx;
    logic [31:0] w, v, m;
    bit legal;
    e = '{default: 0};
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    off   = addr % 4;
    idx   = addr / 4;
    if (!legal || (addr % size == 0 && idx >= MEM_WORDS)) begin
      e.err = 1'b1; e.cause = we ? 4'd7 : 4'd5; e.badaddr = addr; e.lat = 1;
    end else if (addr % size != 0) begin
      e.err = 1'b1; e.cause = we ? 4'd6 : 4'd4; e.badaddr = addr; e.lat = 1;
    end else if (!we) begin
      w = ref_mem[idx];
      if (size == 4) v = w;
      else if (size == 2) begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end else begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      e.rdata = v; e.lat = 2; e.cs = 1;
    end else begin
      m = (size == 4) ? 32'hFFFF_FFFF : (((size == 2) ? 32'hFFFF : 32'hFF) << (8 * off));
      ref_mem[idx] = (ref_mem[idx] & ~m) | ((wd << (8 * off)) & m);
      e.lat = (size == 4) ? 2 : 3;
      e.cs  = (size == 4) ? 1 : 2;
    end
  endtask

  // Monitor: checks memory-side idle values and scores every response.
  always @(negedge clk) begin
    if (rst) begin
      cs_cnt = 0;
    end else begin
      chk("mem_mask", {29'd0, mem_mask_o}, 32'd0);
      if (!mem_cs_o) cs_cnt++;
      else begin
        chk("idle_addr", mem_addr_o, 32'd0);
        chk("idle_data", mem_data_o, 32'd0);
        chk("idle_rdwr", {31'd0, mem_rd_wr_o}, 32'd1);
      end
      if (resp_valid_o) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid 1 expected 0 (t=%0t)", $time);
        end else begin
          mon_e = q.pop_front();
          chk("resp_rdata",   resp_rdata_o, mon_e.rdata);
          chk("resp_err",     {31'd0, resp_err_o}, {31'd0, mon_e.err});
          chk("resp_cause",   {28'd0, resp_cause_o}, {28'd0, mon_e.cause});
          chk("resp_badaddr", resp_badaddr_o, mon_e.badaddr);
          chk("latency",      32'(cyc - mon_e.acc), 32'(mon_e.lat));
          chk("cs_cycles",    32'(cs_cnt), 32'(mon_e.cs));
        end
        cs_cnt = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got ready 0 expected 1 (t=%0t)", $time);
      return;
    end
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    if (track) begin
      model(we, f3, addr, wd, e);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
    ref_mem[1] = 32'h8070_F0A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    chk("rst_ready",   {31'd0, req_ready_o}, 32'd1);
    chk("rst_valid",   {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata",   resp_rdata_o, 32'd0);
    chk("rst_err",     {31'd0, resp_err_o}, 32'd0);
    chk("rst_cause",   {28'd0, resp_cause_o}, 32'd0);
    chk("rst_badaddr", resp_badaddr_o, 32'd0);
    chk("rst_cs",      {31'd0, mem_cs_o}, 32'd1);
    rst = 1'b0;

    // Directed loads on word 1.
    issue(1'b0, 3'b010, 32'h4, 32'd0, 1'b1);
    issue(1'b0, 3'b000, 32'h4, 32'd0, 1'b1);
    issue(1'b0, 3'b100, 32'h7, 32'd0, 1'b1);
    issue(1'b0, 3'b001, 32'h6, 32'd0, 1'b1);
    issue(1'b0, 3'b101, 32'h4, 32'd0, 1'b1);
    // Sub-word stores via read-modify-write.
    issue(1'b1, 3'b000, 32'h5, 32'h0000_0011, 1'b1);
    drain();
    chk("word1_after_sb", dmem[1], 32'h8070_11A5);
    issue(1'b1, 3'b001, 32'h6, 32'h0000_1234, 1'b1);
    drain();
    chk("word1_after_sh", dmem[1], 32'h1234_11A5);
    // Exceptions.
    issue(1'b0, 3'b001, 32'h5,  32'd0, 1'b1);
    issue(1'b1, 3'b010, 32'h2,  32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 3'b010, 32'h40, 32'd0, 1'b1);
    issue(1'b0, 3'b011, 32'h0,  32'd0, 1'b1);
    issue(1'b1, 3'b100, 32'h0,  32'hCAFE_F00D, 1'b1);
    drain();

    // Reset during RMW_RD of SB 0x8: aborted, no response, word 2 intact.
    issue(1'b1, 3'b000, 32'h8, 32'h0000_00EE, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", {31'd0, req_ready_o}, 32'd1);
    chk("abort_cs",    {31'd0, mem_cs_o}, 32'd1);
    chk("abort_addr",  mem_addr_o, 32'd0);
    chk("abort_data",  mem_data_o, 32'd0);
    chk("abort_valid", {31'd0, resp_valid_o}, 32'd0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_word2", dmem[2], ref_mem[2]);
    issue(1'b0, 3'b010, 32'h8, 32'd0, 1'b1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = $urandom_range(0, 4 * MEM_WORDS + 7);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
    end
    drain();

    for (int i = 0; i < MEM_WORDS; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_data_mem_lsu
`default_nettype wire

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store initiator for the word-organised data memory in the 3-stage core. It accepts one load or store per handshake from the execute stage and drives the memory's chip-select, read/write, mask, address and data. It extracts and sign- or zero-extends load data, and performs sub-word stores as read-modify-write of whole words. Misaligned, out-of-range and illegal-size accesses are reported as exceptions to the CSR/trap logic and never reach memory.

## Interface
- MEM_WORDS, 16, number of 32-bit words in data memory; word index ≥ MEM_WORDS is out of range
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request; high only in IDLE
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, low bits used for B/H
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  extended load data; 0 for stores and errors
- resp_err_o  out  1  exception on this completion
- resp_cause_o  out  4  mcause code: 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
- resp_badaddr_o  out  32  faulting byte address (mtval); 0 when no error
- mem_cs_o  out  1  memory chip select, active low
- mem_rd_wr_o  out  1  1 = read, 0 = write
- mem_mask_o  out  3  always 3'b000 (full word); lane handling is internal
- mem_addr_o  out  32  word index = req_addr_i[31:2]
- mem_data_o  out  32  write word
- mem_data_i  in  32  read word (combinational from memory)

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: on req_valid_i & req_ready_o, latch the request and check it, in this priority order:
  - illegal funct3 (loads 011/110/111; stores anything other than 000/001/010) → cause 5 or 7, go to RESP;
  - misaligned (H with addr[0]=1, W with addr[1:0]≠0) → cause 4 or 6, go to RESP;
  - word index ≥ MEM_WORDS → cause 5 or 7, go to RESP;
  - otherwise: load → LOAD; SW → STORE; SB/SH → RMW_RD.
- LOAD: cs=0, rd_wr=1. Register mem_data_i at the end of the cycle. Go to RESP.
- STORE: cs=0, rd_wr=0, data = wdata. Go to RESP.
- RMW_RD: read the word and register it. Go to RMW_WR.
- RMW_WR: write the merged word:
  - SB replaces byte lane addr[1:0];
  - SH replaces halfword lane addr[1];
  - other lanes keep the read value.
  - Go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE.
- Load extraction: select byte lane addr[1:0] or half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W passes through unchanged.
- Erroring requests never assert mem_cs_o.
- Memory-side outputs are combinational from state and latched request. Outside LOAD/STORE/RMW_* they are idle: cs=1, rd_wr=1, addr=0, data=0, mask=000.

## Timing
- Reset values: state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, resp_cause_o=0, resp_badaddr_o=0; memory-side outputs at idle values.
- Latency from accept edge to the resp_valid_o cycle:
  - error: 1 cycle;
  - load: 2 cycles;
  - SW: 2 cycles;
  - SB/SH: 3 cycles.
- Throughput: the next request is accepted in the IDLE cycle after RESP, so there are no back-to-back accepts.
- resp_valid_o has no backpressure; the consumer must sample it in its pulse cycle.
- Response outputs hold their values until the next RESP.
- Reset mid-operation: the next edge returns to IDLE with memory-side outputs idle. An RMW_WR interrupted before its edge still presents its write during that cycle. No response is produced for an aborted request.
- req_valid_i is ignored outside IDLE.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 enum (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - mcause constants (CAUSE_LD_MISALIGN=4, CAUSE_LD_FAULT=5, CAUSE_ST_MISALIGN=6, CAUSE_ST_FAULT=7);
  - the state enum.
- Sub-module `lsu_align` (combinational): load lane extraction/extension, and store lane merge from (old word, wdata, funct3, addr[1:0]).

## Test plan
- Memory word 1 = 0x8070_F0A5; LW 0x4 → 2 cycles, rdata 0x8070_F0A5, err 0, one cs-low read cycle.
- Same word: LB 0x4 → 0xFFFF_FFA5; LBU 0x7 → 0x0000_0080; LH 0x6 → 0xFFFF_8070; LHU 0x4 → 0x0000_F0A5.
- SB 0x5, wdata 0x0000_0011, on word 0x8070_F0A5 → read then write of 0x8070_11A5, resp at cycle 3; SH 0x6, wdata 0x1234 → 0x1234_11A5.
- LH 0x5 → 1 cycle, err 1, cause 4, badaddr 0x5, no cs assertion; SW 0x2 → cause 6.
- LW 0x40 (index 16 with MEM_WORDS=16) → cause 5; load funct3 011 → cause 5; store funct3 100 → cause 7.
- Assert rst during RMW_RD of SB 0x8 → next cycle IDLE, memory outputs idle, no resp_valid_o, word 2 unchanged; a following LW 0x8 completes normally.
